vga_sync_rx: RTL and testbench

Video timing receiver for the 640x480 VGA interface: samples incoming hsync, vsync and 4-bit RGB, locks onto the sync timing, and recovers pixel coordinates, data-enable and pixel colour. It is the receive-side counterpart of the display timing and Pmod VGA output path. Its main uses are loopback self-test of the VGA output and capture of an external video source into downstream frame logic.

---
 rtl/vga_sync_rx.sv | 186 ++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: locks onto incoming hsync/vsync timing and recovers
// active-area coordinates, data-enable and colour two clocks after the pins.
module vga_sync_rx #(
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_START  = 144,
    parameter int unsigned V_START  = 35,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned CORDW    = 10,
    parameter int unsigned CNTW     = 12
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             vga_hsync,
    input  logic             vga_vsync,
    input  logic [3:0]       vga_r,
    input  logic [3:0]       vga_g,
    input  logic [3:0]       vga_b,
    output logic             locked,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de,
    output logic [3:0]       pix_r,
    output logic [3:0]       pix_g,
    output logic [3:0]       pix_b,
    output logic             frame_start,
    output logic [CNTW-1:0]  line_len,
    output logic [7:0]       err_cnt
);

    localparam logic            POL_INV   = (SYNC_POL == 0);
    localparam logic [CNTW-1:0] C_MAX     = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] C_H_LAST  = CNTW'(H_TOTAL - 1);
    localparam logic [CNTW-1:0] C_V_LAST  = CNTW'(V_TOTAL - 1);
    localparam logic [CNTW-1:0] C_H_TMO   = CNTW'(2 * H_TOTAL);
    localparam logic [CNTW-1:0] C_V_TMO   = CNTW'(2 * V_TOTAL);
    localparam logic [CNTW-1:0] C_H_START = CNTW'(H_START);
    localparam logic [CNTW-1:0] C_H_END   = CNTW'(H_START + H_ACTIVE);
    localparam logic [CNTW-1:0] C_V_START = CNTW'(V_START);
    localparam logic [CNTW-1:0] C_V_END   = CNTW'(V_START + V_ACTIVE);

    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

    state_t          r_state, w_state_next;
    logic            r_hs1, r_vs1, r_hs_prev, r_vs_prev;
    logic [3:0]      r_r1, r_g1, r_b1;
    logic            r_vflag, r_bad;
    logic [CNTW-1:0] r_hcnt, r_vcnt;
    logic            w_hedge, w_vedge, w_fedge;
    logic [CNTW-1:0] w_hcnt, w_vcnt;
    logic            w_line_bad, w_frame_good, w_timeout, w_active;
    logic            w_bad_next, w_err_inc, w_lock_next, w_de;

    logic             r_locked, r_de, r_frame_start;
    logic [CORDW-1:0] r_sx, r_sy;
    logic [3:0]       r_pix_r, r_pix_g, r_pix_b;
    logic [CNTW-1:0]  r_line_len;
    logic [7:0]       r_err_cnt;

    // Input stage; syncs normalised so that 1 means asserted.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_hs1     <= 1'b0;
            r_vs1     <= 1'b0;
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_r1      <= 4'd0;
            r_g1      <= 4'd0;
            r_b1      <= 4'd0;
        end else begin
            r_hs1     <= vga_hsync ^ POL_INV;
            r_vs1     <= vga_vsync ^ POL_INV;
            r_hs_prev <= r_hs1;
            r_vs_prev <= r_vs1;
            r_r1      <= vga_r;
            r_g1      <= vga_g;
            r_b1      <= vga_b;
        end
    end

    assign w_hedge = r_hs1 & ~r_hs_prev;
    assign w_vedge = r_vs1 & ~r_vs_prev;
    assign w_fedge = w_hedge & (r_vflag | w_vedge);

    // Counters as seen by the pixel currently in the input stage.
    assign w_hcnt = w_hedge ? '0 : ((r_hcnt == C_MAX) ? r_hcnt : r_hcnt + CNTW'(1));
    assign w_vcnt = w_fedge ? '0 :
                    ((w_hedge && (r_vcnt != C_MAX)) ? r_vcnt + CNTW'(1) : r_vcnt);

    assign w_line_bad   = w_hedge & (r_hcnt != C_H_LAST);
    assign w_frame_good = (r_vcnt == C_V_LAST);
    assign w_timeout    = (w_hcnt >= C_H_TMO) | (w_vcnt >= C_V_TMO);
    assign w_active     = (w_hcnt >= C_H_START) && (w_hcnt < C_H_END) &&
                          (w_vcnt >= C_V_START) && (w_vcnt < C_V_END);

    always_comb begin
        w_state_next = r_state;
        w_bad_next   = r_bad;
        w_err_inc    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                w_bad_next = 1'b0;
                if (w_fedge) w_state_next = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (w_timeout) begin
                    w_state_next = ST_SEARCH;
                end else if (w_fedge) begin
                    if (!r_bad && !w_line_bad && w_frame_good) w_state_next = ST_LOCKED;
                    w_bad_next = 1'b0;
                end else if (w_line_bad) begin
                    w_bad_next = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_line_bad || (w_fedge && !w_frame_good) || w_timeout) begin
                    w_state_next = ST_SEARCH;
                    w_err_inc    = 1'b1;
                end
            end
            default: w_state_next = ST_SEARCH;
        endcase
    end

    assign w_lock_next = (w_state_next == ST_LOCKED);
    assign w_de        = w_active & w_lock_next;

    // Timing state: counters, vsync flag, FSM.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_state <= ST_SEARCH;
            r_bad   <= 1'b0;
            r_vflag <= 1'b0;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_bad   <= w_bad_next;
            r_hcnt  <= w_hcnt;
            r_vcnt  <= w_vcnt;
            if (w_fedge)      r_vflag <= 1'b0;
            else if (w_vedge) r_vflag <= 1'b1;
        end
    end

    // Output registers; de and frame_start already gated by the next lock state.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_locked      <= 1'b0;
            r_de          <= 1'b0;
            r_sx          <= '0;
            r_sy          <= '0;
            r_pix_r       <= 4'd0;
            r_pix_g       <= 4'd0;
            r_pix_b       <= 4'd0;
            r_frame_start <= 1'b0;
            r_line_len    <= '0;
            r_err_cnt     <= 8'd0;
        end else begin
            r_locked      <= w_lock_next;
            r_de          <= w_de;
            r_sx          <= w_de ? CORDW'(w_hcnt - C_H_START) : '0;
            r_sy          <= w_de ? CORDW'(w_vcnt - C_V_START) : '0;
            r_pix_r       <= w_de ? r_r1 : 4'd0;
            r_pix_g       <= w_de ? r_g1 : 4'd0;
            r_pix_b       <= w_de ? r_b1 : 4'd0;
            r_frame_start <= w_de && (w_hcnt == C_H_START) && (w_vcnt == C_V_START);
            if (w_hedge) r_line_len <= (r_hcnt == C_MAX) ? C_MAX : r_hcnt + CNTW'(1);
            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign locked      = r_locked;
    assign de          = r_de;
    assign sx          = r_sx;
    assign sy          = r_sy;
    assign pix_r       = r_pix_r;
    assign pix_g       = r_pix_g;
    assign pix_b       = r_pix_b;
    assign frame_start = r_frame_start;
    assign line_len    = r_line_len;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a scaled-down video mode (32x16 total, 16x10 active)
// with one active-low receiver and one active-high receiver on the same stream.
module tb_vga_sync_rx;

    localparam int HT = 32, HA = 16, HS0 = 20, HS1 = 24, HSTART = 12;
    localparam int VT = 16, VA = 10, VS0 = 12, VS1 = 14, VSTART = 3;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       hs_n, vs_n;
    logic [3:0] r, g, b;

    logic       a_locked, a_de, a_fs, b_locked, b_de, b_fs;
    logic [9:0] a_sx, a_sy, b_sx, b_sy;
    logic [3:0] a_pr, a_pg, a_pb, b_pr, b_pg, b_pb;
    logic [11:0] a_ll, b_ll;
    logic [7:0] a_err, b_err;

    vga_sync_rx #(.SYNC_POL(0), .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HSTART),
                  .V_START(VSTART), .H_ACTIVE(HA), .V_ACTIVE(VA), .CORDW(10), .CNTW(12)) dut (
        .clk_pix(clk), .rst_pix(rst), .vga_hsync(hs_n), .vga_vsync(vs_n),
        .vga_r(r), .vga_g(g), .vga_b(b), .locked(a_locked), .sx(a_sx), .sy(a_sy),
        .de(a_de), .pix_r(a_pr), .pix_g(a_pg), .pix_b(a_pb), .frame_start(a_fs),
        .line_len(a_ll), .err_cnt(a_err));

    vga_sync_rx #(.SYNC_POL(1), .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HSTART),
                  .V_START(VSTART), .H_ACTIVE(HA), .V_ACTIVE(VA), .CORDW(10), .CNTW(12)) dut_p (
        .clk_pix(clk), .rst_pix(rst), .vga_hsync(~hs_n), .vga_vsync(~vs_n),
        .vga_r(r), .vga_g(g), .vga_b(b), .locked(b_locked), .sx(b_sx), .sy(b_sy),
        .de(b_de), .pix_r(b_pr), .pix_g(b_pg), .pix_b(b_pb), .frame_start(b_fs),
        .line_len(b_ll), .err_cnt(b_err));

    int checks = 0, failures = 0;
    int src_x, src_y, src_vtot, short_y, last_x, last_y;
    bit stall, short_en;
    logic [33:0] h_last, h_chk;

    // Expected receiver view of a source pixel: {de, sx, sy, r, g, b, frame_start}.
    function automatic logic [33:0] expect_of(input int x, input int y);
        logic sde;
        logic [9:0] ex, ey;
        logic [3:0] er, eg, eb;
        sde = (x < HA) && (y < VA);
        ex  = sde ? 10'(x) : 10'd0;
        ey  = sde ? 10'(y) : 10'd0;
        er  = sde ? 4'(x) : 4'd0;
        eg  = sde ? 4'(y) : 4'd0;
        eb  = sde ? 4'd4 : 4'd0;
        return {sde, ex, ey, er, eg, eb, sde && (x == 0) && (y == 0)};
    endfunction

    // Drive one source pixel, then advance one clock; h_chk is what the outputs now show.
    task automatic step();
        logic sde;
        h_chk = h_last;
        sde   = (src_x < HA) && (src_y < VA);
        hs_n  = stall ? 1'b1 : !((src_x >= HS0) && (src_x < HS1));
        vs_n  = !((src_y >= VS0) && (src_y < VS1));
        r     = sde ? 4'(src_x) : 4'd0;
        g     = sde ? 4'(src_y) : 4'd0;
        b     = sde ? 4'd4 : 4'd0;
        h_last = expect_of(src_x, src_y);
        last_x = src_x;
        last_y = src_y;
        if (src_x == ((short_en && src_y == short_y) ? HT - 2 : HT - 1)) begin
            if (short_en && src_y == short_y) short_en = 1'b0;
            src_x = 0;
            src_y = (src_y >= src_vtot - 1) ? 0 : src_y + 1;
        end else begin
            src_x = src_x + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int y, input int x);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(last_x == x && last_y == y) && n < 2 * FRAME);
        checks++;
        if (!(last_x == x && last_y == y)) begin
            failures++;
            $display("FAIL run_until position got=(%0d,%0d) exp=(%0d,%0d)", last_y, last_x, y, x);
        end
    endtask

    task automatic wait_lock(input int budget, output int n);
        n = 0;
        while (!a_locked && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (a_locked !== 1'b1) begin
            failures++;
            $display("FAIL wait_lock got locked=%b exp=1 within %0d cycles", a_locked, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; short_en = 1'b0; short_y = 0;
        src_vtot = VT; src_x = 0; src_y = 0; h_last = '0;
        repeat (4) step();
        checks += 2;
        if ({a_locked, a_de, a_sx, a_sy, a_pr, a_pg, a_pb, a_fs, a_ll, a_err} !== 55'd0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0", {a_locked, a_de, a_sx, a_sy, a_pr, a_pg, a_pb, a_fs, a_ll, a_err});
        end
        if ({b_locked, b_de, b_sx, b_sy, b_pr, b_pg, b_pb, b_fs, b_ll, b_err} !== 55'd0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=0", {b_locked, b_de, b_sx, b_sy, b_pr, b_pg, b_pb, b_fs, b_ll, b_err});
        end
        src_x = 0;
        src_y = 0;
        rst = 1'b0;
    endtask

    // First frame edge is pixel 404 (line 12, x 20); the second at 916 qualifies.
    task automatic test_nominal_lock();
        repeat (917) step();
        checks++;
        if (a_locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_early got=%b exp=0", a_locked);
        end
        step();
        checks += 5;
        if (a_locked !== 1'b1) begin failures++; $display("FAIL lock_a got=%b exp=1", a_locked); end
        if (b_locked !== 1'b1) begin failures++; $display("FAIL lock_pol got=%b exp=1", b_locked); end
        if (a_ll !== 12'd32) begin failures++; $display("FAIL line_len got=%0d exp=32", a_ll); end
        if (b_ll !== 12'd32) begin failures++; $display("FAIL line_len_pol got=%0d exp=32", b_ll); end
        if (a_err !== 8'd0) begin failures++; $display("FAIL err_nominal got=%0d exp=0", a_err); end
    endtask

    task automatic test_pixels();
        int nfs = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks += 2;
            if ({a_locked, a_de, a_sx, a_sy, a_pr, a_pg, a_pb, a_fs} !== {1'b1, h_chk}) begin
                failures++;
                $display("FAIL pix_a i=%0d got=%h exp=%h", i,
                         {a_locked, a_de, a_sx, a_sy, a_pr, a_pg, a_pb, a_fs}, {1'b1, h_chk});
            end
            if ({b_locked, b_de, b_sx, b_sy, b_pr, b_pg, b_pb, b_fs} !== {1'b1, h_chk}) begin
                failures++;
                $display("FAIL pix_pol i=%0d got=%h exp=%h", i,
                         {b_locked, b_de, b_sx, b_sy, b_pr, b_pg, b_pb, b_fs}, {1'b1, h_chk});
            end
            if (a_fs) nfs++;
        end
        checks++;
        if (nfs != 2) begin failures++; $display("FAIL frame_start_count got=%0d exp=2", nfs); end
    endtask

    // Line 5 lasts 31 clocks, so the H edge at (6,20) measures a short line.
    task automatic test_short_line();
        int n;
        short_y = 5;
        short_en = 1'b1;
        run_until(6, 20);
        checks++;
        if (a_locked !== 1'b1) begin failures++; $display("FAIL short_pre got=%b exp=1", a_locked); end
        step();
        checks += 5;
        if (a_locked !== 1'b0) begin failures++; $display("FAIL short_drop got=%b exp=0", a_locked); end
        if (a_de !== 1'b0) begin failures++; $display("FAIL short_de got=%b exp=0", a_de); end
        if (a_err !== 8'd1) begin failures++; $display("FAIL short_err got=%0d exp=1", a_err); end
        if (b_err !== 8'd1) begin failures++; $display("FAIL short_err_pol got=%0d exp=1", b_err); end
        if (a_ll !== 12'd31) begin failures++; $display("FAIL short_len got=%0d exp=31", a_ll); end
        wait_lock(3 * FRAME, n);
        checks += 2;
        if (a_err !== 8'd1) begin failures++; $display("FAIL short_relock_err got=%0d exp=1", a_err); end
        if (a_ll !== 12'd32) begin failures++; $display("FAIL short_relock_len got=%0d exp=32", a_ll); end
    endtask

    // After the last H edge, hcnt reaches 64 (2*H_TOTAL) on the 64th following pixel.
    task automatic test_hsync_stall();
        int n;
        run_until(2, 20);
        stall = 1'b1;
        repeat (64) step();
        checks++;
        if (a_locked !== 1'b1) begin failures++; $display("FAIL stall_pre got=%b exp=1", a_locked); end
        step();
        checks += 3;
        if (a_locked !== 1'b0) begin failures++; $display("FAIL stall_drop got=%b exp=0", a_locked); end
        if (a_err !== 8'd2) begin failures++; $display("FAIL stall_err got=%0d exp=2", a_err); end
        if (a_ll !== 12'd32) begin failures++; $display("FAIL stall_len got=%0d exp=32", a_ll); end
        repeat (100) step();
        checks++;
        if (a_err !== 8'd2) begin failures++; $display("FAIL stall_err_once got=%0d exp=2", a_err); end
        stall = 1'b0;
        wait_lock(4 * FRAME, n);
    endtask

    task automatic test_wrong_frame();
        bit seen = 1'b0;
        src_vtot = VT - 1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 4 * HT * (VT - 1); i++) begin
            step();
            if (a_locked || b_locked) seen = 1'b1;
        end
        checks += 3;
        if (seen !== 1'b0) begin failures++; $display("FAIL wrong_frame_locked got=%b exp=0", seen); end
        if (a_err !== 8'd0) begin failures++; $display("FAIL wrong_frame_err got=%0d exp=0", a_err); end
        if (a_ll !== 12'd32) begin failures++; $display("FAIL wrong_frame_len got=%0d exp=32", a_ll); end
    endtask

    task automatic test_async_reset();
        int n;
        src_vtot = VT;
        wait_lock(4 * FRAME, n);
        run_until(4, 5);
        checks++;
        if (a_de !== 1'b1) begin failures++; $display("FAIL areset_pre_de got=%b exp=1", a_de); end
        #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if ({a_locked, a_de, a_sx, a_sy, a_pr, a_pg, a_pb, a_fs, a_ll, a_err} !== 55'd0) begin
            failures++;
            $display("FAIL areset_a got=%h exp=0", {a_locked, a_de, a_sx, a_sy, a_pr, a_pg, a_pb, a_fs, a_ll, a_err});
        end
        if ({b_locked, b_de, b_sx, b_sy, b_pr, b_pg, b_pb, b_fs, b_ll, b_err} !== 55'd0) begin
            failures++;
            $display("FAIL areset_b got=%h exp=0", {b_locked, b_de, b_sx, b_sy, b_pr, b_pg, b_pb, b_fs, b_ll, b_err});
        end
        repeat (3) step();
        rst = 1'b0;
        wait_lock(3 * FRAME, n);
        checks++;
        if (n < FRAME || n > 2 * FRAME) begin
            failures++;
            $display("FAIL areset_relock_time got=%0d exp=%0d..%0d", n, FRAME, 2 * FRAME);
        end
    endtask

    initial begin
        rst = 1'b1;
        hs_n = 1'b1; vs_n = 1'b1;
        r = 4'd0; g = 4'd0; b = 4'd0;
        test_reset();
        test_nominal_lock();
        test_pixels();
        test_short_line();
        test_hsync_stall();
        test_wrong_frame();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
